toy_multicycle_sequencer: RTL and testbench
===========================================

// Module: toy_multicycle_sequencer
// PURPOSE
//   Multi-cycle FSM that sequences the TOY datapath through FETCH/DECODE/EXEC/MEM/WB.
//   Shares one memory port between instruction fetch and data access over a req/ack handshake.
//   Drives PC, IR, ALU, register-file and memory control strobes.
//   Successor to the single-cycle decoder; sits between the IR/flag outputs and the datapath muxes.
// PARAMETERS
//   TIMEOUT_CYCLES  16  max cycles mem_req may wait for mem_ack (used only with TOY_SEQ_TIMEOUT_EN)
// PORTS
//   clk           in   1  single clock, rising edge
//   rst           in   1  synchronous reset, active-high
//   start         in   1  leave IDLE and begin fetching
//   op            in   4  opcode field of IR (valid from DECODE onward)
//   zero          in   1  selected register == 0 (BZ condition)
//   pos           in   1  selected register > 0 (BP condition)
//   mem_ack       in   1  memory completes current access this cycle
//   mem_req       out  1  memory access request
//   mem_we        out  1  1 = write, qualified by mem_req
//   mem_addr_sel  out  2  00 PC, 01 IR addr field, 10 register
//   ir_en         out  1  load IR from memory read data
//   pc_en         out  1  load PC
//   pc_sel        out  2  00 PC+1, 01 IR addr, 10 register
//   alu_op        out  3  = op_q[2:0] during EXEC, else 0
//   reg_we        out  1  register-file write enable
//   wb_sel        out  2  00 ALU, 01 MEM, 10 IMM, 11 PC
//   busy          out  1  state not IDLE/HALT/FAULT
//   halted        out  1  state == HALT
//   fault         out  1  state == FAULT (constant 0 without TOY_SEQ_TIMEOUT_EN)
// BEHAVIOUR
//   - Registered state plus op_q (opcode captured in DECODE); outputs are Moore-decoded from state/op_q.
//   - Reset: state=IDLE, op_q=0. All outputs 0 on the first cycle after rst. rst wins over every event,
//     including mid-handshake; mem_req drops on the next cycle and no strobes fire.
//   - IDLE: all outputs 0; start=1 -> FETCH.
//   - FETCH: mem_req=1, mem_addr_sel=00. mem_req holds until mem_ack=1; ack may arrive in the first cycle.
//     In the ack cycle: ir_en=1, pc_en=1, pc_sel=00 -> DECODE. mem_ack while mem_req=0 is ignored.
//   - DECODE: op_q<=op. Next state:
//     0 -> HALT; 1-6 (ALU) -> EXEC; 7 (LDA) -> WB; 8/A (LOAD/LDI) -> MEM read; 9/B (STORE/STI) -> MEM write;
//     C/D/E/F -> EXEC.
//   - MEM: mem_req=1; mem_we=1 for 9/B; mem_addr_sel=01 for 8/9 and 10 for A/B.
//     Held until mem_ack. In the ack cycle, reads -> WB and writes -> FETCH.
//   - EXEC:
//     ALU ops -> WB.
//     C: pc_en=zero, pc_sel=01. D: pc_en=pos, pc_sel=01. E: pc_en=1, pc_sel=10.
//     F: pc_en=1, pc_sel=01, reg_we=1, wb_sel=11 (PC already holds PC+1).
//     All of C/D/E/F -> FETCH.
//   - WB: reg_we=1 for exactly one cycle; wb_sel=00 ALU, 01 for 8/A, 10 for 7 -> FETCH.
//   - HALT: terminal; start is ignored and only rst exits.
//   - Latency with 0-wait ack: ALU 4, LOAD/LDI 4, STORE/STI 3, LDA/BR/JR/JL 3 cycles. Each wait cycle adds 1.
//   - Every strobe (ir_en, pc_en, reg_we) is asserted at most one cycle per instruction.
// CONFIGURATION
//   TOY_SEQ_TIMEOUT_EN defined:
//     - wait counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 && mem_ack=0.
//     - counter reaching TIMEOUT_CYCLES -> FAULT: outputs 0 except fault=1; only rst exits.
//   Undefined: no counter; waits forever; fault tied to 0; FAULT state unreachable.
// TESTING
//   1 rst 2 cycles, then idle -> all outputs 0, busy=0; start=1 -> mem_req=1 next cycle.
//   2 op=1 (ADD), ack in the first FETCH cycle -> ir_en @c0, alu_op=001 @c2, reg_we/wb_sel=00 @c3, mem_req @c4.
//   3 op=8 (LOAD), data ack after 3 wait cycles -> mem_req high 4 cycles, mem_addr_sel=01, then reg_we with wb_sel=01.
//   4 op=C, zero=1 then zero=0 -> pc_en=1/pc_sel=01 in EXEC vs pc_en=0; both return to FETCH.
//   5 op=9 with rst asserted mid-MEM wait -> next cycle IDLE, mem_req=0, no mem_we pulse; op=0 -> halted=1, start ignored.
//   6 (TOY_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=8) ack never given -> fault=1 after 8 wait cycles, mem_req=0 thereafter.

Source files
------------

// File: rtl/toy_multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the TOY datapath with a shared memory port.
// Define TOY_SEQ_TIMEOUT_EN to add a memory-wait watchdog that parks the sequencer in FAULT.
module toy_multicycle_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] op,
    input  logic       zero,
    input  logic       pos,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] mem_addr_sel,
    output logic       ir_en,
    output logic       pc_en,
    output logic [1:0] pc_sel,
    output logic [2:0] alu_op,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       busy,
    output logic       halted,
    output logic       fault
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StMem,
        StExec,
        StWb,
        StHalt,
        StFault
    } state_e;

    localparam logic [3:0] OpHalt  = 4'h0;
    localparam logic [3:0] OpLda   = 4'h7;
    localparam logic [3:0] OpLoad  = 4'h8;
    localparam logic [3:0] OpStore = 4'h9;
    localparam logic [3:0] OpLdi   = 4'hA;
    localparam logic [3:0] OpSti   = 4'hB;
    localparam logic [3:0] OpBz    = 4'hC;
    localparam logic [3:0] OpBp    = 4'hD;
    localparam logic [3:0] OpJr    = 4'hE;
    localparam logic [3:0] OpJl    = 4'hF;

    state_e     state_q;
    logic [3:0] op_q;
    logic       wait_expired;
    logic       op_q_is_store;
    logic       op_q_is_alu;

    // Odd MEM opcodes (9/B) are the stores; ALU ops are 1-6, i.e. everything below LDA.
    assign op_q_is_store = (op_q == OpStore) || (op_q == OpSti);
    assign op_q_is_alu   = (op_q != OpHalt) && (op_q < OpLda);

`ifdef TOY_SEQ_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] wait_cnt_q;

    assign wait_expired = (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) && mem_req && !mem_ack;
`else
    // No watchdog in this build; the parameter is kept so both builds share one interface.
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign wait_expired   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            op_q    <= '0;
`ifdef TOY_SEQ_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StFetch;
                    end
                end
                StFetch: begin
                    if (mem_ack) begin
                        state_q <= StDecode;
                    end else if (wait_expired) begin
                        state_q <= StFault;
                    end
                end
                StDecode: begin
                    op_q <= op;
                    if (op == OpHalt) begin
                        state_q <= StHalt;
                    end else if (op == OpLda) begin
                        state_q <= StWb;
                    end else if (op >= OpLoad && op <= OpSti) begin
                        state_q <= StMem;
                    end else begin
                        state_q <= StExec;
                    end
                end
                StMem: begin
                    if (mem_ack) begin
                        state_q <= op_q_is_store ? StFetch : StWb;
                    end else if (wait_expired) begin
                        state_q <= StFault;
                    end
                end
                StExec: begin
                    state_q <= op_q_is_alu ? StWb : StFetch;
                end
                StWb: begin
                    state_q <= StFetch;
                end
                StHalt: begin
                    state_q <= StHalt;
                end
                StFault: begin
                    state_q <= StFault;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
`ifdef TOY_SEQ_TIMEOUT_EN
            // Counting only un-acked request cycles clears the counter on every FETCH/MEM entry.
            if (mem_req && !mem_ack) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end else begin
                wait_cnt_q <= '0;
            end
`endif
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 2'b00;
        ir_en        = 1'b0;
        pc_en        = 1'b0;
        pc_sel       = 2'b00;
        alu_op       = 3'b000;
        reg_we       = 1'b0;
        wb_sel       = 2'b00;

        unique case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_en = 1'b1;
                    pc_en = 1'b1;
                end
            end
            StMem: begin
                mem_req      = 1'b1;
                mem_we       = op_q_is_store;
                mem_addr_sel = (op_q == OpLdi || op_q == OpSti) ? 2'b10 : 2'b01;
            end
            StExec: begin
                alu_op = op_q[2:0];
                if (op_q == OpBz) begin
                    pc_en  = zero;
                    pc_sel = 2'b01;
                end else if (op_q == OpBp) begin
                    pc_en  = pos;
                    pc_sel = 2'b01;
                end else if (op_q == OpJr) begin
                    pc_en  = 1'b1;
                    pc_sel = 2'b10;
                end else if (op_q == OpJl) begin
                    // PC already advanced during FETCH, so the link value is PC itself.
                    pc_en  = 1'b1;
                    pc_sel = 2'b01;
                    reg_we = 1'b1;
                    wb_sel = 2'b11;
                end
            end
            StWb: begin
                reg_we = 1'b1;
                if (op_q == OpLoad || op_q == OpLdi) begin
                    wb_sel = 2'b01;
                end else if (op_q == OpLda) begin
                    wb_sel = 2'b10;
                end
            end
            default: begin
            end
        endcase
    end

    assign busy   = (state_q != StIdle) && (state_q != StHalt) && (state_q != StFault);
    assign halted = (state_q == StHalt);

`ifdef TOY_SEQ_TIMEOUT_EN
    assign fault = (state_q == StFault);
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_toy_multicycle_sequencer.sv
// Self-checking bench for toy_multicycle_sequencer: directed scenarios plus random instruction
// streams compared against a per-instruction phase model built from the opcode classes.
module tb_toy_multicycle_sequencer;

    localparam int unsigned TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] op = 4'h0;
    logic       zero = 1'b0;
    logic       pos = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, mem_we, ir_en, pc_en, reg_we, busy, halted, fault;
    logic [1:0] mem_addr_sel, pc_sel, wb_sel;
    logic [2:0] alu_op;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic [1:0] mem_addr_sel;
        logic       ir_en;
        logic       pc_en;
        logic [1:0] pc_sel;
        logic [2:0] alu_op;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       busy;
        logic       halted;
        logic       fault;
    } outs_t;

    outs_t obs;
    int    checks = 0;
    int    errors = 0;

    toy_multicycle_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .zero         (zero),
        .pos          (pos),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_en        (ir_en),
        .pc_en        (pc_en),
        .pc_sel       (pc_sel),
        .alu_op       (alu_op),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .busy         (busy),
        .halted       (halted),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    always_comb obs = {mem_req, mem_we, mem_addr_sel, ir_en, pc_en, pc_sel, alu_op, reg_we,
                       wb_sel, busy, halted, fault};

    task automatic check(input string tag, input outs_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs are applied 1 time unit after the rising edge; outputs are checked mid-cycle.
    task automatic step(input string tag, input outs_t exp);
        #3;
        check(tag, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        start   = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        #3;
        check("reset", '0);
        rst = 1'b0;
    endtask

    task automatic fetch(input int waits, input string tag);
        outs_t e;
        for (int i = 0; i <= waits; i++) begin
            mem_ack   = (i == waits);
            e         = '0;
            e.busy    = 1'b1;
            e.mem_req = 1'b1;
            if (i == waits) begin
                e.ir_en = 1'b1;
                e.pc_en = 1'b1;
            end
            step($sformatf("%s_fetch%0d", tag, i), e);
        end
        mem_ack = 1'b0;
    endtask

    // A stray ack during DECODE must be ignored; op is scrambled afterwards since only op_q counts.
    task automatic decode(input logic [3:0] opc, input string tag);
        outs_t e;
        op      = opc;
        mem_ack = 1'($urandom_range(0, 1));
        e       = '0;
        e.busy  = 1'b1;
        step($sformatf("%s_decode", tag), e);
        op      = 4'($urandom);
        mem_ack = 1'b0;
    endtask

    task automatic writeback(input logic [1:0] sel, input string tag);
        outs_t e;
        e        = '0;
        e.busy   = 1'b1;
        e.reg_we = 1'b1;
        e.wb_sel = sel;
        step($sformatf("%s_wb", tag), e);
    endtask

    // Reference: phases after DECODE follow from the opcode class alone.
    task automatic complete(input logic [3:0] opc, input int dwaits, input logic z,
                            input logic p, input string tag);
        outs_t e;
        zero = z;
        pos  = p;
        e    = '0;
        if (opc == 4'h7) begin
            writeback(2'b10, tag);
        end else if (opc >= 4'h8 && opc <= 4'hB) begin
            for (int i = 0; i <= dwaits; i++) begin
                mem_ack        = (i == dwaits);
                e              = '0;
                e.busy         = 1'b1;
                e.mem_req      = 1'b1;
                e.mem_we       = (opc == 4'h9 || opc == 4'hB);
                e.mem_addr_sel = (opc < 4'hA) ? 2'b01 : 2'b10;
                step($sformatf("%s_mem%0d", tag, i), e);
            end
            mem_ack = 1'b0;
            if (opc == 4'h8 || opc == 4'hA) writeback(2'b01, tag);
        end else begin
            e.busy   = 1'b1;
            e.alu_op = opc[2:0];
            if (opc >= 4'hC) begin
                e.pc_en  = (opc == 4'hC) ? z : (opc == 4'hD) ? p : 1'b1;
                e.pc_sel = (opc == 4'hE) ? 2'b10 : 2'b01;
                if (opc == 4'hF) begin
                    e.reg_we = 1'b1;
                    e.wb_sel = 2'b11;
                end
            end
            step($sformatf("%s_exec", tag), e);
            if (opc < 4'h7) writeback(2'b00, tag);
        end
        zero = 1'($urandom_range(0, 1));
        pos  = 1'($urandom_range(0, 1));
    endtask

    task automatic run_instr(input logic [3:0] opc, input int fw, input int dw, input logic z,
                             input logic p, input string tag);
        fetch(fw, tag);
        decode(opc, tag);
        complete(opc, dw, z, p, tag);
    endtask

    initial begin
        outs_t e;

        // Reset and start.
        do_reset();
        step("idle", '0);
        start = 1'b1;
        step("idle_start", '0);
        start = 1'b0;

        // ADD with immediate ack, then LOAD with three data wait cycles.
        run_instr(4'h1, 0, 0, 1'b0, 1'b0, "add");
        run_instr(4'h8, 0, 3, 1'b0, 1'b0, "load");

        // BZ taken vs not taken.
        run_instr(4'hC, 0, 0, 1'b1, 1'b0, "bz_taken");
        run_instr(4'hC, 1, 0, 1'b0, 1'b1, "bz_not");

        // Random instruction stream over every non-halt opcode.
        for (int n = 0; n < 120; n++) begin
            run_instr(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
        end

        // STORE interrupted by reset during the data wait.
        fetch(0, "st");
        decode(4'h9, "st");
        e              = '0;
        e.busy         = 1'b1;
        e.mem_req      = 1'b1;
        e.mem_we       = 1'b1;
        e.mem_addr_sel = 2'b01;
        mem_ack        = 1'b0;
        step("st_mem_wait", e);
        rst = 1'b1;
        step("st_mem_rst", e);
        rst     = 1'b0;
        mem_ack = 1'b1;
        step("st_after_rst", '0);
        mem_ack = 1'b0;
        step("st_idle", '0);

        // HALT is terminal; start and stray acks are ignored.
        start = 1'b1;
        step("h_start", '0);
        start = 1'b0;
        fetch(1, "h");
        decode(4'h0, "h");
        e        = '0;
        e.halted = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start   = 1'b1;
            mem_ack = 1'($urandom_range(0, 1));
            step($sformatf("halt%0d", i), e);
        end
        do_reset();
        step("post_halt_idle", '0);

        start = 1'b1;
        step("wd_start", '0);
        start = 1'b0;
`ifdef TOY_SEQ_TIMEOUT_EN
        e         = '0;
        e.busy    = 1'b1;
        e.mem_req = 1'b1;
        for (int i = 0; i < int'(TO); i++) begin
            step($sformatf("to_wait%0d", i), e);
        end
        e       = '0;
        e.fault = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start   = 1'b1;
            mem_ack = 1'($urandom_range(0, 1));
            step($sformatf("to_fault%0d", i), e);
        end
        start   = 1'b0;
        mem_ack = 1'b0;
        do_reset();
        step("to_cleared", '0);
`else
        // Without the watchdog a long wait must simply continue.
        run_instr(4'hA, 20, 12, 1'b0, 1'b0, "nowd");
        fetch(0, "nowd_h");
        decode(4'h0, "nowd_h");
        e        = '0;
        e.halted = 1'b1;
        step("nowd_halt", e);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
